apu_frame_counter: RTL and testbench
====================================

# apu_frame_counter

Frame sequencer for the APU. It generates the quarter-frame and half-frame clock pulses that the pulse channels consume as `iEnvelope_clk`/`iLength_clk`/`iSweep_clk`. It is programmed by CPU writes to register $4017 and raises the frame IRQ. It replaces the ad-hoc `clkDivider` pair with a sequence that is mode-correct and software-controllable.

## Interface
Parameters:
- `STEP_CYCLES`, default 7457: enabled cycles per sequencer step; must be ≥ 2.

Ports:
- `clk`  in  1  APU clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cycle_en`  in  1  APU cycle enable; the step counter advances only when this is high.
- `wr_en`  in  1  single-cycle strobe for a write to $4017.
- `wr_data`  in  8  write data; bit 7 = mode (0 = 4-step, 1 = 5-step), bit 6 = IRQ inhibit, bits 5:0 ignored.
- `irq_ack`  in  1  single-cycle strobe that clears the frame IRQ (the $4015 read side effect).
- `quarter_frame`  out  1  one-`clk`-wide pulse.
- `half_frame`  out  1  one-`clk`-wide pulse.
- `frame_irq`  out  1  level; frame interrupt flag.
- `step`  out  3  number of steps completed in the current sequence.

## Operation
- Registers:
  - `mode`, `inhibit` (from $4017)
  - step timer `cnt`, width `$clog2(STEP_CYCLES)`
  - `step`, range 0..4
  - `irq` flag
- Reset (asynchronous, on `reset` low): all registers and all outputs are 0. This selects 4-step mode with IRQ enabled.
- Terminal count: when `cycle_en` is high and `cnt == STEP_CYCLES-1`, `cnt` wraps to 0 and one step completes. Otherwise, when `cycle_en` is high, `cnt` increments. When `cycle_en` is low, everything holds.
- 4-step mode, step completions 1, 2, 3, 4:
  - Quarter-frame pulse on every step.
  - Half-frame pulse on steps 2 and 4.
  - Step 4 sets `irq` unless `inhibit` is set.
  - `step` sequence: 0 → 1 → 2 → 3 → 0.
- 5-step mode, step completions 1..5:
  - Quarter-frame pulse on steps 1, 2, 3 and 5; none on step 4.
  - Half-frame pulse on steps 2 and 5.
  - `irq` is never set.
  - `step` sequence: 0 → 1 → 2 → 3 → 4 → 0.
- $4017 write (`wr_en` high):
  - Latch `mode` and `inhibit`; clear `cnt` and `step` to 0.
  - If the new mode is 5-step, emit quarter- and half-frame pulses immediately.
  - If the new `inhibit` is 1, clear `irq`.
  - The write is not gated by `cycle_en`.
- IRQ clear: `irq_ack` clears `irq`.
- Priority order:
  - Write beats terminal count in the same cycle; the terminal step is discarded.
  - IRQ set beats `irq_ack` in the same cycle; the flag stays 1.
  - Inhibit-write clear beats set; the flag becomes 0.
- Mode change takes effect from the write itself. A sequence in progress is abandoned and never completed.

## Timing
- All outputs are registered.
- Pulses: asserted in the `clk` cycle after the terminal-count edge (or the write edge), for exactly one `clk`, regardless of `cycle_en`.
- `frame_irq`: rises in the same cycle as the step-4 `quarter_frame`. It falls the cycle after `irq_ack` or after an inhibit write.
- `step`: updates in the same cycle as the corresponding pulse.
- First step after reset or after a write: the terminal count arrives on the `STEP_CYCLES`-th enabled cycle following it.
- Step period is `STEP_CYCLES` enabled cycles, with no drift across sequence wrap.
- Reset asserted mid-pulse forces the pulse low immediately (asynchronous); no pulse is emitted on reset release.

## Structure
- Shared package `apu_pkg` holds:
  - `FRAME_MODE_4STEP = 1'b0`, `FRAME_MODE_5STEP = 1'b1`
  - `APU_REG_FRAME = 16'h4017`
  - `FRAME_STEP_CYCLES_DEFAULT = 7457`
  - step-decode constants for the quarter-frame and half-frame masks per mode
- Sub-module `apu_step_timer`: modulo-`STEP_CYCLES` counter with enable and synchronous clear, outputting a terminal-count strobe.
- The sequencer and IRQ logic live in the top level.

## Test plan
All scenarios use `STEP_CYCLES = 4` with `cycle_en = 1` unless noted.
- Reset release, no write → `quarter_frame` every 4 clk. `half_frame` on every 2nd quarter pulse. `frame_irq` rises with the 4th quarter pulse (clk 16 after release). `step` runs 1, 2, 3, 0.
- Write `8'h80` → quarter + half pulse on the next clk. Then quarter pulses at steps 1, 2, 3, 5, half pulses at steps 2, 5, with no pulse at step 4. `frame_irq` stays 0 over 3 sequences.
- `frame_irq` = 1, then write `8'h40` → IRQ clears the next clk. It stays 0 across 3 four-step sequences. Write `8'h00` → IRQ sets again 16 clk later.
- `irq_ack` while `frame_irq` = 1 → 0 the next clk. `irq_ack` coincident with the step-4 set → `frame_irq` = 1.
- Write coincident with terminal count → no pulse from that step; `cnt` and `step` restart; the next quarter pulse comes 4 clk later.
- `cycle_en` toggling 1, 0 → pulse spacing is 8 clk. `reset` low mid-sequence → all outputs 0 asynchronously; after release, the first pulse comes 4 enabled cycles later in 4-step mode.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU definitions: frame-counter register address, modes and per-step
// quarter/half-frame decode masks.
package apu_pkg;

  typedef enum logic {
    FRAME_MODE_4STEP = 1'b0,
    FRAME_MODE_5STEP = 1'b1
  } frame_mode_e;

  typedef struct packed {
    frame_mode_e mode;
    logic        inhibit;
  } frame_cfg_t;

  localparam logic [15:0] APU_REG_FRAME             = 16'h4017;
  localparam int unsigned FRAME_STEP_CYCLES_DEFAULT = 7457;

  // Bit i set means step completion i+1 emits the pulse.
  localparam logic [4:0] FRAME_QF_MASK_4STEP = 5'b01111;
  localparam logic [4:0] FRAME_HF_MASK_4STEP = 5'b01010;
  localparam logic [4:0] FRAME_QF_MASK_5STEP = 5'b10111;
  localparam logic [4:0] FRAME_HF_MASK_5STEP = 5'b10010;

  // Takes $4017 bits [7:6]; bits [5:0] carry nothing for the frame counter.
  function automatic frame_cfg_t decode_frame_wr(input logic [1:0] hi_bits);
    frame_cfg_t cfg;
    cfg.mode    = frame_mode_e'(hi_bits[1]);
    cfg.inhibit = hi_bits[0];
    return cfg;
  endfunction

endpackage

// File: rtl/apu_step_timer.sv
// Modulo-STEP_CYCLES step timer with enable and synchronous clear; tc marks
// the enabled cycle on which the count wraps.
module apu_step_timer #(
  parameter  int unsigned STEP_CYCLES = 7457,
  localparam int unsigned CNT_W       = $clog2(STEP_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en) begin
      if (cnt == LAST)  cnt <= '0;
      else              cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: 4/5-step quarter/half-frame pulse generation, $4017
// programming and frame IRQ.
module apu_frame_counter
  import apu_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = FRAME_STEP_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cycle_en,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic [2:0] step
);

  frame_mode_e mode;
  logic        inhibit;
  logic        tc;
  frame_cfg_t  cfg;
  logic [4:0]  qf_mask, hf_mask;
  logic        last_step, irq_set;
  logic        unused_wr_bits;

  assign cfg            = decode_frame_wr(wr_data[7:6]);
  assign unused_wr_bits = ^wr_data[5:0];

  // A write restarts the timer; clr also swallows a coincident terminal count.
  apu_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (cycle_en),
    .clr   (wr_en),
    .tc    (tc)
  );

  always_comb begin
    qf_mask   = FRAME_QF_MASK_4STEP;
    hf_mask   = FRAME_HF_MASK_4STEP;
    last_step = (step == 3'd3);
    if (mode == FRAME_MODE_5STEP) begin
      qf_mask   = FRAME_QF_MASK_5STEP;
      hf_mask   = FRAME_HF_MASK_5STEP;
      last_step = (step == 3'd4);
    end
    irq_set = tc && (mode == FRAME_MODE_4STEP) && (step == 3'd3) && !inhibit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode          <= FRAME_MODE_4STEP;
      inhibit       <= 1'b0;
      step          <= '0;
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      frame_irq     <= 1'b0;
    end else begin
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      if (wr_en) begin
        mode    <= cfg.mode;
        inhibit <= cfg.inhibit;
        step    <= '0;
        if (cfg.mode == FRAME_MODE_5STEP) begin
          quarter_frame <= 1'b1;
          half_frame    <= 1'b1;
        end
        if (cfg.inhibit || irq_ack) frame_irq <= 1'b0;
      end else begin
        if (tc) begin
          quarter_frame <= qf_mask[step];
          half_frame    <= hf_mask[step];
          step          <= last_step ? 3'd0 : step + 3'd1;
        end
        if (irq_set)      frame_irq <= 1'b1;
        else if (irq_ack) frame_irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apu_frame_counter.sv
// Bench for apu_frame_counter with STEP_CYCLES=4 against a count-based model.
module tb_apu_frame_counter;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cycle_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       irq_ack = 1'b0;
  logic       quarter_frame, half_frame, frame_irq;
  logic [2:0] step;

  apu_frame_counter #(.STEP_CYCLES(SC)) dut (
    .clk           (clk),
    .reset         (reset),
    .cycle_en      (cycle_en),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .irq_ack       (irq_ack),
    .quarter_frame (quarter_frame),
    .half_frame    (half_frame),
    .frame_irq     (frame_irq),
    .step          (step)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: counts enabled cycles since the last restart; completion number
  // and pulse pattern follow from that count divided by the step length.
  bit m_mode, m_inh, m_irq, m_qf, m_hf;
  int m_n, m_step;

  function automatic logic [5:0] exp_vec();
    return {m_qf, m_hf, m_irq, 3'(m_step)};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {quarter_frame, half_frame, frame_irq, step};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_inh = 0; m_irq = 0; m_qf = 0; m_hf = 0; m_n = 0; m_step = 0;
  endtask

  task automatic model_edge(input bit en, input bit wr, input logic [7:0] d, input bit ack);
    int len, k;
    bit set;
    m_qf = 0; m_hf = 0; set = 0;
    if (wr) begin
      m_mode = d[7]; m_inh = d[6]; m_n = 0; m_step = 0;
      if (d[7]) begin m_qf = 1; m_hf = 1; end
      if (d[6] || ack) m_irq = 0;
    end else begin
      if (en) begin
        m_n++;
        if (m_n % SC == 0) begin
          len    = m_mode ? 5 : 4;
          k      = ((m_n / SC - 1) % len) + 1;
          m_step = k % len;
          m_qf   = m_mode ? (k != 4) : 1'b1;
          m_hf   = m_mode ? (k == 2 || k == 5) : (k == 2 || k == 4);
          set    = !m_mode && k == 4 && !m_inh;
        end
      end
      if (set) m_irq = 1;
      else if (ack) m_irq = 0;
    end
  endtask

  // Drive one clk of stimulus; returns #1 after the edge with strobes dropped.
  task automatic cyc(input bit en, input bit wr, input logic [7:0] d, input bit ack);
    cycle_en = en; wr_en = wr; wr_data = d; irq_ack = ack;
    @(posedge clk);
    model_edge(en, wr, d, ack);
    #1;
    wr_en = 0; irq_ack = 0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if (dut_vec() !== 6'b0) begin
      n_fail++; $display("FAIL reset_state: got %b expected %b", dut_vec(), 6'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (dut_vec() !== 6'b0) begin
      n_fail++; $display("FAIL reset_hold: got %b expected %b", dut_vec(), 6'b0);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_four_step();
    int rise = -1, nq = 0;
    for (int i = 1; i <= 48; i++) begin
      cyc(1, 0, 8'($urandom), 0);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL four_step cyc %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (frame_irq === 1'b1 && rise < 0) rise = i;
      if (quarter_frame === 1'b1) nq++;
    end
    n_tests++;
    if (rise !== 16) begin
      n_fail++; $display("FAIL four_step_irq_rise: got %0d expected %0d", rise, 16);
    end
    n_tests++;
    if (nq !== 12) begin
      n_fail++; $display("FAIL four_step_qf_count: got %0d expected %0d", nq, 12);
    end
  endtask

  task automatic test_five_step();
    int nq = 0, nh = 0;
    bit irq_seen = 0;
    cyc(1, 1, 8'h80, 1);
    n_tests++;
    if ({quarter_frame, half_frame, frame_irq} !== 3'b110) begin
      n_fail++; $display("FAIL five_step_write_pulse: got %b expected %b",
                         {quarter_frame, half_frame, frame_irq}, 3'b110);
    end
    for (int i = 1; i <= 60; i++) begin
      cyc(1, 0, 8'h00, 0);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL five_step cyc %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (frame_irq !== 1'b0) irq_seen = 1;
      if (quarter_frame === 1'b1) nq++;
      if (half_frame === 1'b1) nh++;
    end
    n_tests++;
    if (irq_seen !== 1'b0 || nq !== 12 || nh !== 6) begin
      n_fail++; $display("FAIL five_step_totals: got irq=%0d qf=%0d hf=%0d expected irq=0 qf=12 hf=6",
                         irq_seen, nq, nh);
    end
  endtask

  task automatic test_inhibit();
    int rise = -1;
    bit irq_seen = 0;
    cyc(1, 1, 8'h00, 0);
    repeat (16) cyc(1, 0, 8'h00, 0);
    n_tests++;
    if (frame_irq !== 1'b1) begin
      n_fail++; $display("FAIL inhibit_pre_irq: got %b expected 1", frame_irq);
    end
    cyc(1, 1, 8'h40, 0);
    n_tests++;
    if (frame_irq !== 1'b0) begin
      n_fail++; $display("FAIL inhibit_clear: got %b expected 0", frame_irq);
    end
    for (int i = 1; i <= 48; i++) begin
      cyc(1, 0, 8'h00, 0);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL inhibit cyc %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (frame_irq !== 1'b0) irq_seen = 1;
    end
    n_tests++;
    if (irq_seen !== 1'b0) begin
      n_fail++; $display("FAIL inhibit_hold: got irq seen=%0d expected 0", irq_seen);
    end
    cyc(1, 1, 8'h00, 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 8'h00, 0);
      if (frame_irq === 1'b1 && rise < 0) rise = i;
    end
    n_tests++;
    if (rise !== 16) begin
      n_fail++; $display("FAIL inhibit_rearm_rise: got %0d expected %0d", rise, 16);
    end
  endtask

  task automatic test_irq_ack();
    cyc(1, 0, 8'h00, 1);
    n_tests++;
    if (frame_irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_ack_clear: got %b expected 0", frame_irq);
    end
    cyc(1, 1, 8'h00, 0);
    repeat (15) cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 1);
    n_tests++;
    if ({quarter_frame, frame_irq} !== 2'b11) begin
      n_fail++; $display("FAIL irq_ack_vs_set: got qf,irq=%b expected 11", {quarter_frame, frame_irq});
    end
  endtask

  task automatic test_write_at_tc();
    int first = -1;
    cyc(1, 1, 8'h00, 0);
    repeat (3) cyc(1, 0, 8'h00, 0);
    cyc(1, 1, 8'h00, 0);
    n_tests++;
    if ({quarter_frame, half_frame, step} !== 5'b0) begin
      n_fail++; $display("FAIL write_at_tc: got %b expected %b", {quarter_frame, half_frame, step}, 5'b0);
    end
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 0, 8'h00, 0);
      if (quarter_frame === 1'b1 && first < 0) first = i;
    end
    n_tests++;
    if (first !== 4) begin
      n_fail++; $display("FAIL write_at_tc_restart: got %0d expected %0d", first, 4);
    end
  endtask

  task automatic test_cycle_en();
    int last = -1, bad = 0, npulse = 0;
    cyc(1, 1, 8'h00, 0);
    for (int i = 1; i <= 40; i++) begin
      cyc(i % 2 == 1, 0, 8'h00, 0);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL cycle_en cyc %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (quarter_frame === 1'b1) begin
        if (last >= 0 && i - last != 8) bad++;
        last = i; npulse++;
      end
    end
    n_tests++;
    if (bad !== 0 || npulse !== 5) begin
      n_fail++; $display("FAIL cycle_en_spacing: got bad gaps=%0d pulses=%0d expected 0 and 5", bad, npulse);
    end
  endtask

  task automatic test_async_reset();
    int first = -1;
    cyc(1, 1, 8'h80, 0);
    reset = 1'b0;
    #1;
    n_tests++;
    if (dut_vec() !== 6'b0) begin
      n_fail++; $display("FAIL async_reset: got %b expected %b", dut_vec(), 6'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 8'h00, 0);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL post_reset cyc %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (quarter_frame === 1'b1 && first < 0) first = i;
    end
    n_tests++;
    if (first !== 4) begin
      n_fail++; $display("FAIL post_reset_first_pulse: got %0d expected %0d", first, 4);
    end
  endtask

  task automatic test_random();
    bit en, wr, ack;
    for (int i = 1; i <= 1500; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      wr  = ($urandom_range(0, 39) == 0);
      ack = ($urandom_range(0, 19) == 0);
      cyc(en, wr, 8'($urandom), ack);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_four_step();
    test_five_step();
    test_inhibit();
    test_irq_ack();
    test_write_at_tc();
    test_cycle_en();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
